// File: rtl/mul_seq_pkg.sv
// Shared register map, control/status bit positions and FSM encoding for mul_seq_ctrl.
package mul_seq_pkg;

    localparam logic [2:0] ADDR_A    = 3'd0;
    localparam logic [2:0] ADDR_B    = 3'd1;
    localparam logic [2:0] ADDR_CTRL = 3'd2;
    localparam logic [2:0] ADDR_P_LO = 3'd3;
    localparam logic [2:0] ADDR_P_HI = 3'd4;

    localparam int CTRL_GO  = 0;
    localparam int CTRL_CLR = 1;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/DRegister.sv
// Enabled D register with asynchronous active-high clear.
// Latency: 1 cycle from en to q.
// Backpressure: none; holds q while en is low.
module DRegister #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/lat_counter.sv
// Loadable down-counter that times the multiplier pipeline; zero flags the capture cycle.
// Latency: load takes effect on the next edge; zero is combinational from the count.
// Backpressure: none; dec is ignored once the count reaches zero.
module lat_counter #(
    parameter int LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CW = $clog2(LATENCY) + 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= CW'(LATENCY - 1);
        else if (dec && (cnt != '0))
            cnt <= cnt - CW'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mul_seq_ctrl.sv
// Register-mapped sequencer for a fixed-latency pipelined multiplier: issue one op, capture product.
// Latency: GO write edge to done is LATENCY+1 edges; back-to-back rate one op per LATENCY+2 cycles.
// Backpressure: bus writes to A/B/GO/CLR are dropped while busy; a dropped GO sets sticky err.
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [2:0]         addr,
    input  logic [WIDTH-1:0]   wd,
    output logic [WIDTH-1:0]   rd,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    output logic               mul_valid,
    input  logic [2*WIDTH-1:0] mul_p,
    output logic               busy,
    output logic               done
);

    state_t state, state_nx;

    logic               ctrl_wr, go, clr;
    logic               wr_a, wr_b;
    logic               cap, cnt_load, cnt_dec, cnt_zero;
    logic               err, err_nx;
    logic [2*WIDTH-1:0] p_q;

    assign busy    = (state == ST_ISSUE) || (state == ST_WAIT);
    assign done    = (state == ST_DONE);

    assign ctrl_wr = we && (addr == ADDR_CTRL);
    assign go      = ctrl_wr && wd[CTRL_GO];
    assign clr     = ctrl_wr && wd[CTRL_CLR];
    assign wr_a    = we && (addr == ADDR_A) && !busy;
    assign wr_b    = we && (addr == ADDR_B) && !busy;

    DRegister #(.WIDTH(WIDTH)) u_reg_a (
        .clk (clk), .rst (rst), .en (wr_a), .d (wd), .q (mul_a)
    );

    DRegister #(.WIDTH(WIDTH)) u_reg_b (
        .clk (clk), .rst (rst), .en (wr_b), .d (wd), .q (mul_b)
    );

    DRegister #(.WIDTH(2*WIDTH)) u_reg_p (
        .clk (clk), .rst (rst), .en (cap), .d (mul_p), .q (p_q)
    );

    lat_counter #(.LATENCY(LATENCY)) u_lat (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .dec  (cnt_dec),
        .zero (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            err   <= err_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        mul_valid = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cap       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go)
                    state_nx = ST_ISSUE;
            end
            ST_ISSUE: begin
                mul_valid = 1'b1;
                cnt_load  = 1'b1;
                state_nx  = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_zero) begin
                    cap      = 1'b1;
                    state_nx = ST_DONE;
                end else begin
                    cnt_dec  = 1'b1;
                end
            end
            ST_DONE: begin
                // GO takes priority when GO and CLR arrive in the same write
                if (go)
                    state_nx = ST_ISSUE;
                else if (clr)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        err_nx = err;
        if (busy && go)
            err_nx = 1'b1;
        else if (!busy && (go || clr))
            err_nx = 1'b0;
    end

    always_comb begin
        rd = '0;
        case (addr)
            ADDR_A:    rd = mul_a;
            ADDR_B:    rd = mul_b;
            ADDR_CTRL: begin
                rd[STAT_BUSY] = busy;
                rd[STAT_DONE] = done;
                rd[STAT_ERR]  = err;
            end
            ADDR_P_LO: rd = p_q[WIDTH-1:0];
            ADDR_P_HI: rd = p_q[2*WIDTH-1:WIDTH];
            default:   rd = '0;
        endcase
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Randomized scoreboard bench for mul_seq_ctrl (LATENCY=4) plus a short directed check of a LATENCY=1 build.
module tb_mul_seq_ctrl;
    import mul_seq_pkg::*;

    localparam int W = 32;
    localparam int L = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          we, we1;
    logic [2:0]    addr, addr1;
    logic [W-1:0]  wd, wd1, rd, rd1;
    logic [W-1:0]  mul_a, mul_b, mul_a1, mul_b1;
    logic          mul_valid, mul_valid1;
    logic [2*W-1:0] mul_p, mul_p1;
    logic          busy, done, busy1, done1;

    mul_seq_ctrl #(.WIDTH(W), .LATENCY(L)) dut (
        .clk (clk), .rst (rst), .we (we), .addr (addr), .wd (wd), .rd (rd),
        .mul_a (mul_a), .mul_b (mul_b), .mul_valid (mul_valid), .mul_p (mul_p),
        .busy (busy), .done (done)
    );

    mul_seq_ctrl #(.WIDTH(W), .LATENCY(1)) dut1 (
        .clk (clk), .rst (rst), .we (we1), .addr (addr1), .wd (wd1), .rd (rd1),
        .mul_a (mul_a1), .mul_b (mul_b1), .mul_valid (mul_valid1), .mul_p (mul_p1),
        .busy (busy1), .done (done1)
    );

    // Multiplier models: product appears LATENCY edges after the issue edge, garbage otherwise
    logic [63:0] pipe [L];
    logic [63:0] pipe1;
    always @(posedge clk) begin
        pipe[0] <= mul_valid ? 64'(mul_a) * 64'(mul_b) : {$urandom, $urandom};
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        pipe1 <= mul_valid1 ? 64'(mul_a1) * 64'(mul_b1) : {$urandom, $urandom};
    end
    assign mul_p  = pipe[L-1];
    assign mul_p1 = pipe1;

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: m_start is the edge at which the last accepted GO was sampled
    logic [31:0] m_a = '0, m_b = '0;
    logic [63:0] m_p = '0, m_pn = '0;
    int          m_start = -1;
    bit          m_err = 1'b0;

    function automatic bit m_busy(input int c);
        return (m_start >= 0) && (c >= m_start) && (c <= m_start + L);
    endfunction

    function automatic bit m_done(input int c);
        return (m_start >= 0) && (c >= m_start + L + 1);
    endfunction

    function automatic logic [63:0] m_pval(input int c);
        return m_done(c) ? m_pn : m_p;
    endfunction

    typedef struct {
        int          c;
        logic [31:0] a;
        logic [31:0] b;
    } iss_t;

    iss_t        iss_q [$];
    int          done_q [$];
    logic [31:0] rd_q [$];
    logic        rd_req = 1'b0;
    bit          done_d = 1'b0;

    // Monitor: compares DUT outputs against queued expectations every cycle
    always @(negedge clk) begin
        if (rd_req) begin
            if (rd_q.size() == 0) chk("rd_queue_underflow", 64'd1, 64'd0);
            else chk($sformatf("rd[%0d]", addr), 64'(rd), 64'(rd_q.pop_front()));
        end
        chk("busy", 64'(busy), 64'(m_busy(cyc)));
        chk("done", 64'(done), 64'(m_done(cyc)));
        if (mul_valid) begin
            if (iss_q.size() == 0) begin
                chk("mul_valid_unexpected", 64'd1, 64'd0);
            end else begin
                iss_t e;
                e = iss_q.pop_front();
                chk("issue_cycle", 64'(cyc), 64'(e.c));
                chk("mul_a", 64'(mul_a), 64'(e.a));
                chk("mul_b", 64'(mul_b), 64'(e.b));
            end
        end
        if (done && !done_d) begin
            if (done_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
            else chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
        end
        done_d <= done;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        int c, e;
        c = cyc;
        we = 1'b1; addr = a; wd = d;
        step();
        we = 1'b0;
        e = cyc;
        if (!m_busy(c)) begin
            if (a == ADDR_A) m_a = d;
            else if (a == ADDR_B) m_b = d;
            else if (a == ADDR_CTRL && d[0]) begin
                if (m_done(c)) m_p = m_pn;
                m_pn = 64'(m_a) * 64'(m_b);
                m_start = e;
                m_err = 1'b0;
                iss_q.push_back('{e, m_a, m_b});
                done_q.push_back(e + L + 1);
            end else if (a == ADDR_CTRL && d[1]) begin
                if (m_done(c)) m_p = m_pn;
                m_start = -1;
                m_err = 1'b0;
            end
        end else if (a == ADDR_CTRL && d[0]) begin
            m_err = 1'b1;
        end
    endtask

    task automatic rd_chk(input logic [2:0] a);
        logic [31:0] v;
        logic [63:0] p;
        int c;
        c = cyc;
        p = m_pval(c);
        v = '0;
        case (a)
            ADDR_A:    v = m_a;
            ADDR_B:    v = m_b;
            ADDR_CTRL: v = {29'd0, m_err, m_done(c), m_busy(c)};
            ADDR_P_LO: v = p[31:0];
            ADDR_P_HI: v = p[63:32];
            default:   v = '0;
        endcase
        rd_q.push_back(v);
        addr = a;
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_a = '0; m_b = '0; m_p = '0; m_pn = '0;
        m_start = -1; m_err = 1'b0;
        iss_q.delete();
        done_q.delete();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 50) begin
            step();
            k++;
        end
        if (!done) chk("wait_done_timeout", 64'(done), 64'd1);
    endtask

    task automatic wr1(input logic [2:0] a, input logic [31:0] d);
        we1 = 1'b1; addr1 = a; wd1 = d;
        step();
        we1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int e1;
        logic [2:0] ra;
        rst = 1'b1;
        we = 1'b0; addr = '0; wd = '0;
        we1 = 1'b0; addr1 = '0; wd1 = '0;
        step(2);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) rd_chk(3'(i));

        // Basic multiply
        bus_wr(ADDR_A, 32'd3);
        bus_wr(ADDR_B, 32'd5);
        bus_wr(ADDR_CTRL, 32'h1);
        wait_done();
        rd_chk(ADDR_P_LO); rd_chk(ADDR_P_HI); rd_chk(ADDR_CTRL);

        // Full width
        bus_wr(ADDR_A, 32'hFFFF_FFFF);
        bus_wr(ADDR_B, 32'hFFFF_FFFF);
        bus_wr(ADDR_CTRL, 32'h1);
        wait_done();
        rd_chk(ADDR_P_HI); rd_chk(ADDR_P_LO); rd_chk(ADDR_CTRL);

        // GO and A write while busy
        bus_wr(ADDR_A, 32'd7);
        bus_wr(ADDR_B, 32'd9);
        bus_wr(ADDR_CTRL, 32'h1);
        step();
        bus_wr(ADDR_CTRL, 32'h1);
        bus_wr(ADDR_A, 32'h1234);
        wait_done();
        rd_chk(ADDR_A); rd_chk(ADDR_P_LO); rd_chk(ADDR_CTRL);
        bus_wr(ADDR_CTRL, 32'h2);
        rd_chk(ADDR_CTRL);

        // GO+CLR from DONE
        bus_wr(ADDR_CTRL, 32'h1);
        wait_done();
        bus_wr(ADDR_CTRL, 32'h3);
        rd_chk(ADDR_CTRL);
        wait_done();
        rd_chk(ADDR_P_LO); rd_chk(ADDR_CTRL);

        // Reset mid-WAIT, then a clean multiply
        bus_wr(ADDR_A, 32'd11);
        bus_wr(ADDR_CTRL, 32'h1);
        step();
        do_reset();
        step(L + 3);
        for (int i = 0; i < 8; i++) rd_chk(3'(i));
        bus_wr(ADDR_A, 32'd6);
        bus_wr(ADDR_B, 32'd7);
        bus_wr(ADDR_CTRL, 32'h1);
        wait_done();
        rd_chk(ADDR_P_LO); rd_chk(ADDR_P_HI);

        // Randomized traffic
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 10))
                0, 1: bus_wr(ADDR_A, $urandom);
                2, 3: bus_wr(ADDR_B, $urandom);
                4:    bus_wr(ADDR_CTRL, ($urandom & 32'hFFFF_FFFC) | 32'h1 | ($urandom_range(0, 1) << 1));
                5:    bus_wr(ADDR_CTRL, 32'h2);
                6, 7: begin
                    ra = 3'($urandom_range(0, 7));
                    rd_chk(ra);
                end
                8:    step($urandom_range(0, 6));
                9:    bus_wr(3'($urandom_range(5, 7)), $urandom);
                default: if (m_start >= 0) wait_done();
            endcase
        end
        step(L + 3);
        for (int i = 0; i < 5; i++) rd_chk(3'(i));
        chk("issue_queue_drained", 64'(iss_q.size()), 64'd0);
        chk("done_queue_drained", 64'(done_q.size()), 64'd0);

        // LATENCY=1 build
        wr1(ADDR_A, 32'h1234_5678);
        wr1(ADDR_B, 32'h10);
        wr1(ADDR_CTRL, 32'h1);
        e1 = cyc;
        chk("l1_mul_valid", 64'(mul_valid1), 64'd1);
        chk("l1_busy_issue", 64'(busy1), 64'd1);
        step();
        chk("l1_cycle_a", 64'(cyc - e1), 64'd1);
        chk("l1_done_early", 64'(done1), 64'd0);
        chk("l1_busy_wait", 64'(busy1), 64'd1);
        step();
        chk("l1_done", 64'(done1), 64'd1);
        chk("l1_busy_done", 64'(busy1), 64'd0);
        addr1 = ADDR_P_LO; #1;
        chk("l1_p_lo", 64'(rd1), 64'h2345_6780);
        addr1 = ADDR_P_HI; #1;
        chk("l1_p_hi", 64'(rd1), 64'h1);
        addr1 = ADDR_CTRL; #1;
        chk("l1_status", 64'(rd1), 64'h2);
        for (int i = 5; i < 8; i++) begin
            addr1 = 3'(i); #1;
            chk($sformatf("l1_rd[%0d]", i), 64'(rd1), 64'd0);
        end
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
